rob_commit_unit: RTL
====================

Name: rob_commit_unit

Overview:
- Reorder buffer: the ROB end of the register-file/ROB interface.
- Accepts renamed instructions from the register file (values, PC-based tags, op, rd, pc) and resolves their pending operands against in-flight results.
- Forwards resolved instructions to the reservation stations and retires them in order back to the register file.
- Raises a flush toward the register file on a mispredicted or redirecting instruction.

Parameters:
- DEPTH, 16, number of entries; power of two.
- PTR_W, 4, log2(DEPTH).
- OP_W, 6, opcode width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- is_empty_from_rf  in  1  0 = valid issue this cycle
- pc_from_rf  in  32  instruction pc, also its tag
- rd_from_rf  in  5  destination register
- op_from_rf  in  OP_W  opcode
- imm_from_rf  in  32  immediate
- v1_from_rf / v2_from_rf  in  32  operand values
- q1_from_rf / q2_from_rf  in  32  operand tags; 0 = value valid
- cdb_valid  in  1  result broadcast
- cdb_pc  in  32  tag of the producing instruction
- cdb_data  in  32  result value
- cdb_redirect  in  1  instruction requires flush
- cdb_target  in  32  redirect pc
- is_full_to_decoder  out  1  stall request
- is_empty_to_rs  out  1  0 = valid dispatch
- pc/rd/op/imm/v1/v2/q1/q2 _to_rs  out  as inputs  resolved instruction
- is_commit_to_rf  out  1  in-order write-back pulse
- rd_to_rf  out  5  destination register
- data_to_rf  out  32  value
- pc_to_rf  out  32  entry pc on commit; redirect target on exception
- is_exception_to_rf  out  1  flush pulse

Behaviour:
- Reset (synchronous, rst high at posedge):
  - All entries invalid; head, tail and count = 0.
  - is_empty_to_rs = 1; is_full_to_decoder = 0.
  - is_commit_to_rf = 0, is_exception_to_rf = 0.
  - All data outputs = 0.
  - rst has priority over every other event, including mid-flush.
- Entry fields: valid, ready, redirect, pc, rd, value, target.
- Allocate:
  - When is_empty_from_rf = 0, write the entry at tail with ready = 0; tail++ (wraps mod DEPTH); count++.
  - If count == DEPTH, the issue is dropped and a simulation error is flagged.
- is_full_to_decoder = (count >= DEPTH-2). This is combinational from registered count and absorbs the decoder-to-rf pipeline slot.
- Operand resolution, per operand, when qN_from_rf != 0:
  - If cdb_valid and cdb_pc == qN in the same cycle: vN = cdb_data, qN = 0 (bypass).
  - Else if the youngest valid entry with pc == qN is ready: vN = that value, qN = 0.
  - Else pass through unchanged.
  - When qN == 0, pass through unchanged.
- Dispatch to RS: registered with 1-cycle latency. is_empty_to_rs mirrors is_empty_from_rf, delayed one cycle.
- CDB: marks the oldest valid, not-ready entry whose pc == cdb_pc. Sets ready, value, redirect and target. No match is ignored.
- Commit, evaluated each cycle on the registered head state:
  - If head is valid and ready without redirect, retire it: head++, count--.
  - Next cycle, is_commit_to_rf = (rd != 0), with rd_to_rf, data_to_rf = value, pc_to_rf = pc.
  - rd == 0 retires silently.
  - At most one retire per cycle.
  - A CDB write and a commit of the same entry cannot coincide; the entry becomes ready at the edge and commits at the next edge.
- Simultaneous allocate and retire: count unchanged; pointers both advance.
- Redirect commit, when the head is ready with redirect = 1:
  - Next cycle: is_exception_to_rf = 1, is_commit_to_rf = 0, rd_to_rf = rd, data_to_rf = value (link), pc_to_rf = target.
  - On that same edge, all entries are invalidated; head = tail = count = 0; is_empty_to_rs = 1.
  - An issue arriving on the flush edge is discarded.
- Pulses (is_commit_to_rf, is_exception_to_rf) last exactly one cycle; data outputs hold their last value.

Test Plan:
- Issue pc=0x10 rd=3 q1=q2=0, then CDB pc=0x10 data=7 → RS dispatch 1 cycle after issue; commit rd=3 data=7 pc=0x10 is_commit_to_rf=1 two cycles after CDB.
- Issue 0x10 (rd=5), then 0x14 with q1=0x10 while CDB broadcasts 0x10 data=0xAB in the same cycle → v1_to_rs=0xAB, q1_to_rs=0.
- Fill 14 entries without results → is_full_to_decoder=1 at count=14. Resolve the head → after commit, count=13 and full deasserts.
- Results arrive out of order (0x18, 0x14, 0x10) → commits emerge in order 0x10, 0x14, 0x18 on consecutive cycles.
- Head 0x20 rd=1 CDB redirect target=0x100 data=0x24, younger entries pending → is_exception_to_rf=1, pc_to_rf=0x100, data_to_rf=0x24; count=0; a later CDB for a younger pc has no effect.
- Assert rst with 5 entries live and a commit pending → next cycle all outputs at reset values; no commit pulse.

Source files
------------

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: reorder buffer resolving issued operands, dispatching to the RS and retiring in order to the RF.
// A ready head carrying a redirect flushes the whole buffer instead of committing.
module rob_commit_unit #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int OP_W  = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            is_empty_from_rf,
    input  logic [31:0]     pc_from_rf,
    input  logic [4:0]      rd_from_rf,
    input  logic [OP_W-1:0] op_from_rf,
    input  logic [31:0]     imm_from_rf,
    input  logic [31:0]     v1_from_rf,
    input  logic [31:0]     v2_from_rf,
    input  logic [31:0]     q1_from_rf,
    input  logic [31:0]     q2_from_rf,
    input  logic            cdb_valid,
    input  logic [31:0]     cdb_pc,
    input  logic [31:0]     cdb_data,
    input  logic            cdb_redirect,
    input  logic [31:0]     cdb_target,
    output logic            is_full_to_decoder,
    output logic            is_empty_to_rs,
    output logic [31:0]     pc_to_rs,
    output logic [4:0]      rd_to_rs,
    output logic [OP_W-1:0] op_to_rs,
    output logic [31:0]     imm_to_rs,
    output logic [31:0]     v1_to_rs,
    output logic [31:0]     v2_to_rs,
    output logic [31:0]     q1_to_rs,
    output logic [31:0]     q2_to_rs,
    output logic            is_commit_to_rf,
    output logic [4:0]      rd_to_rf,
    output logic [31:0]     data_to_rf,
    output logic [31:0]     pc_to_rf,
    output logic            is_exception_to_rf
);
    logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d, redir_q, redir_d;
    logic [31:0]      pc_q [DEPTH], pc_d [DEPTH], value_q [DEPTH], value_d [DEPTH];
    logic [31:0]      target_q [DEPTH], target_d [DEPTH];
    logic [4:0]       rd_q [DEPTH], rd_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, cdb_idx, idx;
    logic [PTR_W:0]   count_q, count_d;
    logic             empty_rs_q, empty_rs_d, commit_q, commit_d, exc_q, exc_d;
    logic [31:0]      pc_rs_q, pc_rs_d, imm_rs_q, imm_rs_d, v1_rs_q, v1_rs_d, v2_rs_q, v2_rs_d;
    logic [31:0]      q1_rs_q, q1_rs_d, q2_rs_q, q2_rs_d, data_rf_q, data_rf_d, pc_rf_q, pc_rf_d;
    logic [4:0]       rd_rs_q, rd_rs_d, rd_rf_q, rd_rf_d;
    logic [OP_W-1:0]  op_rs_q, op_rs_d;
    logic             alloc, retire, flush, cdb_hit;
    logic [63:0]      r1, r2;

    // Returns {q, v}; the youngest matching entry decides, later matches overwrite earlier ones.
    function automatic logic [63:0] resolve(input logic [31:0] v, input logic [31:0] q);
        logic             rdy;
        logic [31:0]      val;
        logic [PTR_W-1:0] i;
        rdy = 1'b0;
        val = v;
        for (int k = 0; k < DEPTH; k++) begin
            i = head_q + PTR_W'(k);
            if (valid_q[i] && pc_q[i] == q) begin
                rdy = ready_q[i];
                val = value_q[i];
            end
        end
        return (q == 32'd0) ? {q, v} : (cdb_valid && cdb_pc == q) ? {32'd0, cdb_data} :
               rdy ? {32'd0, val} : {q, v};
    endfunction

    always_comb begin
        valid_d   = valid_q;
        ready_d   = ready_q;
        redir_d   = redir_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        value_d   = value_q;
        target_d  = target_q;
        head_d    = head_q;
        tail_d    = tail_q;
        commit_d  = 1'b0;
        exc_d     = 1'b0;
        rd_rf_d   = rd_rf_q;
        data_rf_d = data_rf_q;
        pc_rf_d   = pc_rf_q;
        pc_rs_d   = pc_rs_q;
        rd_rs_d   = rd_rs_q;
        op_rs_d   = op_rs_q;
        imm_rs_d  = imm_rs_q;
        v1_rs_d   = v1_rs_q;
        v2_rs_d   = v2_rs_q;
        q1_rs_d   = q1_rs_q;
        q2_rs_d   = q2_rs_q;
        retire    = valid_q[head_q] && ready_q[head_q] && !redir_q[head_q];
        flush     = valid_q[head_q] && ready_q[head_q] && redir_q[head_q];
        alloc     = !is_empty_from_rf && count_q != (PTR_W+1)'(DEPTH) && !flush;
        empty_rs_d = !alloc;
        r1        = resolve(v1_from_rf, q1_from_rf);
        r2        = resolve(v2_from_rf, q2_from_rf);
        cdb_hit   = 1'b0;
        cdb_idx   = head_q;
        idx       = head_q;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = head_q + PTR_W'(k);
            if (cdb_valid && valid_q[idx] && !ready_q[idx] && pc_q[idx] == cdb_pc) begin
                cdb_hit = 1'b1;
                cdb_idx = idx;
            end
        end
        if (cdb_hit) begin
            ready_d[cdb_idx]  = 1'b1;
            value_d[cdb_idx]  = cdb_data;
            redir_d[cdb_idx]  = cdb_redirect;
            target_d[cdb_idx] = cdb_target;
        end
        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
            commit_d        = rd_q[head_q] != 5'd0;
            rd_rf_d         = commit_d ? rd_q[head_q] : rd_rf_q;
            data_rf_d       = commit_d ? value_q[head_q] : data_rf_q;
            pc_rf_d         = commit_d ? pc_q[head_q] : pc_rf_q;
        end
        if (alloc) begin
            valid_d[tail_q]  = 1'b1;
            ready_d[tail_q]  = 1'b0;
            redir_d[tail_q]  = 1'b0;
            pc_d[tail_q]     = pc_from_rf;
            rd_d[tail_q]     = rd_from_rf;
            value_d[tail_q]  = 32'd0;
            target_d[tail_q] = 32'd0;
            tail_d           = tail_q + PTR_W'(1);
            pc_rs_d          = pc_from_rf;
            rd_rs_d          = rd_from_rf;
            op_rs_d          = op_from_rf;
            imm_rs_d         = imm_from_rf;
            {q1_rs_d, v1_rs_d} = r1;
            {q2_rs_d, v2_rs_d} = r2;
        end
        count_d = count_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(retire);
        if (flush) begin
            valid_d   = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            exc_d     = 1'b1;
            rd_rf_d   = rd_q[head_q];
            data_rf_d = value_q[head_q];
            pc_rf_d   = target_q[head_q];
        end
    end

    always_ff @(posedge clk) begin
        pc_q     <= pc_d;
        rd_q     <= rd_d;
        value_q  <= value_d;
        target_q <= target_d;
    end

    always_ff @(posedge clk) begin
        assert (rst || is_empty_from_rf || flush || count_q != (PTR_W+1)'(DEPTH))
            else $error("rob_commit_unit: issue dropped, buffer full");
        if (rst) begin
            valid_q <= '0; ready_q <= '0; redir_q <= '0;
            head_q <= '0; tail_q <= '0; count_q <= '0;
            empty_rs_q <= 1'b1; commit_q <= 1'b0; exc_q <= 1'b0;
            pc_rs_q <= '0; rd_rs_q <= '0; op_rs_q <= '0; imm_rs_q <= '0;
            v1_rs_q <= '0; v2_rs_q <= '0; q1_rs_q <= '0; q2_rs_q <= '0;
            rd_rf_q <= '0; data_rf_q <= '0; pc_rf_q <= '0;
        end else begin
            valid_q <= valid_d; ready_q <= ready_d; redir_q <= redir_d;
            head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
            empty_rs_q <= empty_rs_d; commit_q <= commit_d; exc_q <= exc_d;
            pc_rs_q <= pc_rs_d; rd_rs_q <= rd_rs_d; op_rs_q <= op_rs_d; imm_rs_q <= imm_rs_d;
            v1_rs_q <= v1_rs_d; v2_rs_q <= v2_rs_d; q1_rs_q <= q1_rs_d; q2_rs_q <= q2_rs_d;
            rd_rf_q <= rd_rf_d; data_rf_q <= data_rf_d; pc_rf_q <= pc_rf_d;
        end
    end

    assign is_full_to_decoder = count_q >= (PTR_W+1)'(DEPTH - 2);
    assign is_empty_to_rs     = empty_rs_q;
    assign pc_to_rs           = pc_rs_q;
    assign rd_to_rs           = rd_rs_q;
    assign op_to_rs           = op_rs_q;
    assign imm_to_rs          = imm_rs_q;
    assign v1_to_rs           = v1_rs_q;
    assign v2_to_rs           = v2_rs_q;
    assign q1_to_rs           = q1_rs_q;
    assign q2_to_rs           = q2_rs_q;
    assign is_commit_to_rf    = commit_q;
    assign rd_to_rf           = rd_rf_q;
    assign data_to_rf         = data_rf_q;
    assign pc_to_rf           = pc_rf_q;
    assign is_exception_to_rf = exc_q;
endmodule
